// File: rtl/keystream_xor_engine.sv
// -----------------------------------------------------------------------------
// keystream_xor_engine
//
// Consumer end of the stream-cipher keystream interface. Each accepted data
// byte triggers exactly one keystream request to the hash generator; the
// returned keystream byte is XORed with the data byte and presented
// downstream. Encrypt and decrypt are the same operation.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. data_in_ready/data_in_valid carry the upstream byte,
// data_out_valid/data_out_ready carry the result. Once data_out_valid rises
// it stays high, and data_out stays constant, until the transfer completes
// or session_start/rst intervenes.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   session_start             pulse: restart session, resets keystream
//   data_in / _valid / _ready upstream byte channel
//   data_out / _valid / _ready downstream byte channel
//   request_hash_byte_pulse   one-cycle keystream request
//   reset_hash                one-cycle keystream reset (session_start only)
//   hash_byte_in / hash_byte_pulse_in  keystream byte from generator
//   byte_count                bytes completed since session_start/rst
//   error                     sticky generator-timeout flag
//   state_dbg_o               current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module keystream_xor_engine #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   session_start,
  input  logic [7:0]             data_in,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic [7:0]             data_out,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   request_hash_byte_pulse,
  output logic                   reset_hash,
  input  logic [7:0]             hash_byte_in,
  input  logic                   hash_byte_pulse_in,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic                   error,
  output logic [2:0]             state_dbg_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQUEST  = 3'd1;
  localparam logic [2:0] ST_WAIT_KEY = 3'd2;
  localparam logic [2:0] ST_OUTPUT   = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  // Timer counts 0..TIMEOUT_CYCLES-1 while waiting for the keystream byte.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]             state_q, state_d;
  logic [7:0]             in_byte_q, in_byte_d;
  logic [7:0]             dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   din_ready_q, din_ready_d;
  logic                   req_q, req_d;
  logic                   rst_hash_q, rst_hash_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d;
  logic [TW-1:0]          timer_q, timer_d;

  always_comb begin
    state_d      = state_q;
    in_byte_d    = in_byte_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    din_ready_d  = din_ready_q;
    req_d        = 1'b0;
    rst_hash_d   = 1'b0;
    count_d      = count_q;
    err_d        = err_q;
    timer_d      = timer_q;

    if (session_start) begin
      // Session restart overrides everything in flight, including a keystream
      // pulse arriving this same cycle; any latched byte is abandoned.
      state_d      = ST_IDLE;
      din_ready_d  = 1'b1;
      dout_valid_d = 1'b0;
      count_d      = '0;
      err_d        = 1'b0;
      timer_d      = '0;
      rst_hash_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_in_valid && din_ready_q) begin
            in_byte_d   = data_in;
            din_ready_d = 1'b0;
            // Registered request is high exactly while the FSM sits in REQUEST.
            req_d       = 1'b1;
            state_d     = ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          timer_d = '0;
          state_d = ST_WAIT_KEY;
        end
        ST_WAIT_KEY: begin
          // A pulse on the final timer cycle still completes normally.
          if (hash_byte_pulse_in) begin
            dout_d       = in_byte_q ^ hash_byte_in;
            dout_valid_d = 1'b1;
            state_d      = ST_OUTPUT;
          end else if (timer_q == TIMER_LAST) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_OUTPUT: begin
          if (data_out_ready) begin
            dout_valid_d = 1'b0;
            count_d      = count_q + COUNT_WIDTH'(1);
            din_ready_d  = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_ERROR: begin
          // Parked until session_start or rst; no requests issued.
          din_ready_d  = 1'b0;
          dout_valid_d = 1'b0;
        end
        default: begin
          state_d      = ST_IDLE;
          din_ready_d  = 1'b1;
          dout_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_byte_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
      req_q        <= 1'b0;
      rst_hash_q   <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      in_byte_q    <= in_byte_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
      req_q        <= req_d;
      rst_hash_q   <= rst_hash_d;
      count_q      <= count_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
    end
  end

  assign data_in_ready           = din_ready_q;
  assign data_out                = dout_q;
  assign data_out_valid          = dout_valid_q;
  assign request_hash_byte_pulse = req_q;
  assign reset_hash              = rst_hash_q;
  assign byte_count              = count_q;
  assign error                   = err_q;
  assign state_dbg_o             = state_q;

endmodule

// File: tb/tb_keystream_xor_engine.sv
// -----------------------------------------------------------------------------
// tb_keystream_xor_engine
//
// Drives keystream_xor_engine with TIMEOUT_CYCLES=8 and COUNT_WIDTH=2. A
// behavioural keystream generator (a table indexed by bytes served since the
// last keystream reset) answers each request after a chosen latency. Expected
// output bytes are queued when the keystream byte is handed out and popped
// when data_out is observed.
// -----------------------------------------------------------------------------
module tb_keystream_xor_engine;

  localparam int TO = 8;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          session_start;
  logic [7:0]    data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [7:0]    data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          request_hash_byte_pulse;
  logic          reset_hash;
  logic [7:0]    hash_byte_in;
  logic          hash_byte_pulse_in;
  logic [CW-1:0] byte_count;
  logic          error;
  logic [2:0]    state_dbg;

  keystream_xor_engine #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .session_start           (session_start),
    .data_in                 (data_in),
    .data_in_valid           (data_in_valid),
    .data_in_ready           (data_in_ready),
    .data_out                (data_out),
    .data_out_valid          (data_out_valid),
    .data_out_ready          (data_out_ready),
    .request_hash_byte_pulse (request_hash_byte_pulse),
    .reset_hash              (reset_hash),
    .hash_byte_in            (hash_byte_in),
    .hash_byte_pulse_in      (hash_byte_pulse_in),
    .byte_count              (byte_count),
    .error                   (error),
    .state_dbg_o             (state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] ks_tbl [256];
  int         ks_idx;
  logic [7:0] exp_q [$];
  int         exp_count;
  logic [7:0] ct [16];
  logic       prev_req = 1'b0;
  logic       prev_rh  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Request and reset_hash are single-cycle strobes.
  always @(negedge clk) begin
    if (!rst && request_hash_byte_pulse) chk("req_not_back_to_back", 32'(prev_req), 32'd0);
    if (!rst && reset_hash) chk("reset_hash_one_cycle", 32'(prev_rh), 32'd0);
    prev_req <= request_hash_byte_pulse;
    prev_rh  <= reset_hash;
  end

  // ---------------- driver tasks ----------------
  task automatic do_session();
    session_start = 1'b1;
    tick();
    session_start = 1'b0;
    ks_idx    = 0;
    exp_count = 0;
    chk("sess_reset_hash", 32'(reset_hash), 32'd1);
    chk("sess_error", 32'(error), 32'd0);
    chk("sess_din_ready", 32'(data_in_ready), 32'd1);
    chk("sess_count", 32'(byte_count), 32'd0);
    chk("sess_valid", 32'(data_out_valid), 32'd0);
    tick();
    chk("sess_reset_hash_drop", 32'(reset_hash), 32'd0);
  endtask

  // One full byte: accept, request, keystream after lat cycles, bp cycles of
  // backpressure (optionally with a stray keystream pulse), then handshake.
  task automatic send_byte(input logic [7:0] d, input int lat, input int bp,
                           input bit stray, output logic [7:0] got);
    logic [7:0] exp_b;
    int w;
    data_in = d;
    data_in_valid = 1'b1;
    w = 0;
    while (!data_in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("din_ready_wait", 32'(data_in_ready), 32'd1);
    tick();
    data_in_valid = 1'b0;
    data_in = 8'($urandom);
    chk("req_at_n_plus_1", 32'(request_hash_byte_pulse), 32'd1);
    chk("din_ready_drop", 32'(data_in_ready), 32'd0);
    for (int k = 0; k < lat; k++) begin
      tick();
      chk("no_early_valid", 32'(data_out_valid), 32'd0);
      chk("no_extra_req", 32'(request_hash_byte_pulse), 32'd0);
    end
    hash_byte_in = ks_tbl[ks_idx];
    exp_q.push_back(d ^ ks_tbl[ks_idx]);
    ks_idx++;
    hash_byte_pulse_in = 1'b1;
    tick();
    hash_byte_pulse_in = 1'b0;
    hash_byte_in = 8'($urandom);
    chk("valid_after_pulse", 32'(data_out_valid), 32'd1);
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk("data_out", 32'(data_out), 32'(exp_b));
    chk("error_clear", 32'(error), 32'd0);
    got = data_out;
    for (int b = 0; b < bp; b++) begin
      if (stray && b == 0) begin
        hash_byte_pulse_in = 1'b1;
        hash_byte_in = 8'hFF;
      end
      data_out_ready = 1'b0;
      tick();
      hash_byte_pulse_in = 1'b0;
      chk("hold_valid", 32'(data_out_valid), 32'd1);
      chk("hold_data", 32'(data_out), 32'(exp_b));
      chk("hold_count", 32'(byte_count), 32'(exp_count));
      chk("hold_no_req", 32'(request_hash_byte_pulse), 32'd0);
    end
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chk("hs_valid_drop", 32'(data_out_valid), 32'd0);
    chk("hs_count", 32'(byte_count), 32'(exp_count));
    chk("hs_din_ready", 32'(data_in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] got;
    int wrap_exp [5];
    wrap_exp = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 256; i++) ks_tbl[i] = 8'($urandom);
    ks_tbl[0] = 8'h3C;

    rst = 1'b1; session_start = 1'b0; data_in = '0; data_in_valid = 1'b0;
    data_out_ready = 1'b0; hash_byte_in = '0; hash_byte_pulse_in = 1'b0;
    @(negedge clk);
    tick(); tick(); tick();
    rst = 1'b0;
    ks_idx = 0;
    exp_count = 0;
    chk("rst_din_ready", 32'(data_in_ready), 32'd1);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_req", 32'(request_hash_byte_pulse), 32'd0);
    chk("rst_reset_hash", 32'(reset_hash), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Basic + backpressure with stray pulse: 0xA5 ^ 0x3C.
    send_byte(8'hA5, 5, 10, 1'b1, got);
    chk("basic_value", 32'(got), 32'h99);
    chk("basic_count", 32'(byte_count), 32'd1);

    // Keystream arriving on the last allowed WAIT_KEY cycle still wins.
    send_byte(8'h5A, TO, 0, 1'b0, got);
    chk("limit_no_error", 32'(error), 32'd0);

    // Timeout: no keystream pulse at all.
    data_in = 8'($urandom);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    chk("to_req", 32'(request_hash_byte_pulse), 32'd1);
    for (int k = 1; k <= TO + 1; k++) begin
      tick();
      if (k <= TO) chk("to_no_early_error", 32'(error), 32'd0);
      else chk("to_error_set", 32'(error), 32'd1);
    end
    chk("to_din_ready", 32'(data_in_ready), 32'd0);
    data_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hash_byte_pulse_in = (k == 1);
      tick();
      chk("err_no_req", 32'(request_hash_byte_pulse), 32'd0);
      chk("err_no_valid", 32'(data_out_valid), 32'd0);
      chk("err_sticky", 32'(error), 32'd1);
    end
    hash_byte_pulse_in = 1'b0;
    data_in_valid = 1'b0;
    do_session();

    // Restart in the middle of WAIT_KEY with a simultaneous keystream pulse.
    data_in = 8'($urandom);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    chk("mid_req", 32'(request_hash_byte_pulse), 32'd1);
    tick(); tick();
    session_start = 1'b1;
    hash_byte_pulse_in = 1'b1;
    hash_byte_in = ks_tbl[ks_idx];
    tick();
    session_start = 1'b0;
    hash_byte_pulse_in = 1'b0;
    ks_idx = 0;
    exp_count = 0;
    chk("mid_no_valid", 32'(data_out_valid), 32'd0);
    chk("mid_count", 32'(byte_count), 32'd0);
    chk("mid_reset_hash", 32'(reset_hash), 32'd1);
    chk("mid_din_ready", 32'(data_in_ready), 32'd1);
    tick();
    chk("mid_no_valid_later", 32'(data_out_valid), 32'd0);
    chk("mid_reset_hash_drop", 32'(reset_hash), 32'd0);

    // Counter wrap over 5 bytes (2-bit counter).
    do_session();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom), $urandom_range(1, TO), $urandom_range(0, 2), 1'b0, got);
      chk("count_wrap", 32'(byte_count), 32'(wrap_exp[i]));
    end

    // Stream: encrypt 0x00..0x0F, restart keystream, decrypt the ciphertext.
    do_session();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), $urandom_range(1, TO), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), got);
      ct[i] = got;
    end
    chk("enc_count", 32'(byte_count), 32'(16 % (1 << CW)));
    do_session();
    for (int i = 0; i < 16; i++) begin
      send_byte(ct[i], $urandom_range(1, TO), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), got);
      chk("decrypt", 32'(got), 32'(i));
    end
    chk("dec_count", 32'(byte_count), 32'(16 % (1 << CW)));
    chk("final_error", 32'(error), 32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
